pipelined_rca_adder: RTL and testbench

- Parametrised, pipelined successor to the team's fixed-width ripple-carry adder.
- Splits a WIDTH-bit add/subtract into WIDTH/SEG ripple-carry segments, one segment per pipeline stage, with the carry registered between stages.
- Valid/ready handshake on both sides with full backpressure.
- Sits in datapaths where a single WIDTH-bit ripple chain cannot close timing.

---
 rtl/pipelined_rca_adder.sv | 136 +++++++++++++
 tb/tb_pipelined_rca_adder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry add/subtract: one SEG-bit ripple segment per stage, carry registered
// between stages, valid/ready handshake. Define PIPE_ADDER_OVF_EN to add the signed overflow port ovf.
module pipelined_rca_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int unsigned SEG_SAFE = (SEG < 1) ? 1 : SEG;
    localparam int unsigned STAGES   = WIDTH / SEG_SAFE;

    if ((SEG < 1) || ((WIDTH % SEG_SAFE) != 0)) begin : g_param_check
        $error("pipelined_rca_adder: WIDTH must be a non-zero multiple of SEG, SEG >= 1");
    end

    // Returns {carry into segment MSB, carry out, sum}.
    function automatic logic [SEG_SAFE+1:0] seg_add(input logic [SEG_SAFE-1:0] x,
                                                    input logic [SEG_SAFE-1:0] y,
                                                    input logic                ci);
        logic [SEG_SAFE-1:0] s;
        logic                c;
        logic                c_prev;
        s      = '0;
        c      = ci;
        c_prev = ci;
        for (int i = 0; i < int'(SEG_SAFE); i++) begin
            c_prev = c;
            s[i]   = x[i] ^ y[i] ^ c;
            c      = ((x[i] ^ y[i]) & c) | (x[i] & y[i]);
        end
        return {c_prev, c, s};
    endfunction

    logic [WIDTH-1:0]    a_q   [STAGES];
    logic [WIDTH-1:0]    a_d   [STAGES];
    logic [WIDTH-1:0]    b_q   [STAGES];
    logic [WIDTH-1:0]    b_d   [STAGES];
    logic [WIDTH-1:0]    s_q   [STAGES];
    logic [WIDTH-1:0]    s_d   [STAGES];
    logic [STAGES-1:0]   c_q, c_d;
    logic [STAGES-1:0]   v_q, v_d;

    logic [WIDTH-1:0]    a_in  [STAGES];
    logic [WIDTH-1:0]    b_in  [STAGES];
    logic [WIDTH-1:0]    s_in  [STAGES];
    logic [STAGES-1:0]   c_in, v_in;
    logic [SEG_SAFE+1:0] seg_r [STAGES];

    logic adv;

    assign adv       = !v_q[STAGES-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];

    always_comb begin
        a_in[0] = a;
        b_in[0] = b ^ {WIDTH{sub}};
        s_in[0] = '0;
        c_in[0] = sub | cin;
        v_in[0] = in_valid;
        for (int k = 1; k < int'(STAGES); k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
            v_in[k] = v_q[k-1];
        end
        // Each stage fills its own segment; lower segments ride along, upper ones wait.
        for (int k = 0; k < int'(STAGES); k++) begin
            seg_r[k] = seg_add(a_in[k][k*SEG_SAFE +: SEG_SAFE],
                               b_in[k][k*SEG_SAFE +: SEG_SAFE], c_in[k]);
            a_d[k]   = a_in[k];
            b_d[k]   = b_in[k];
            s_d[k]   = s_in[k];
            s_d[k][k*SEG_SAFE +: SEG_SAFE] = seg_r[k][SEG_SAFE-1:0];
            c_d[k]   = seg_r[k][SEG_SAFE];
            v_d[k]   = v_in[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            c_q <= '0;
            v_q <= '0;
        end else if (adv) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
            c_q <= c_d;
            v_q <= v_d;
        end
    end

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_d, ovf_q;

    always_comb begin
        ovf_d = seg_r[STAGES-1][SEG_SAFE+1] ^ seg_r[STAGES-1][SEG_SAFE];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Directed scoreboard bench for pipelined_rca_adder (32/8 and 16/16 instances).
module tb_pipelined_rca_adder;
    localparam int STG = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
    logic [31:0] a, b, sum;
    logic        in_valid16, in_ready16, cin16, sub16, out_valid16, out_ready16, cout16;
    logic [15:0] a16, b16, sum16;
`ifdef PIPE_ADDER_OVF_EN
    logic        ovf, ovf16;
`endif

    always #5 clk = ~clk;

    pipelined_rca_adder #(.WIDTH(32), .SEG(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    pipelined_rca_adder #(.WIDTH(16), .SEG(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .a(a16), .b(b16),
        .cin(cin16), .sub(sub16), .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .cout(cout16)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(ovf16)
`endif
    );

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        int          t;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          pops = 0;
    int          pops0;
    bit          acc = 1'b0;
    bit          chk_lat = 1'b1;
    bit          hold_v = 1'b0;
    logic [32:0] held;

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic ci, input logic sb_op, input int t);
        logic [32:0] r;
        exp_t        e;
        if (sb_op) r = {1'b0, x} + {1'b0, ~y} + 33'd1;
        else       r = {1'b0, x} + {1'b0, y} + {32'd0, ci};
        e.s = r[31:0];
        e.c = r[32];
        e.o = sb_op ? ((x[31] != y[31]) && (r[31] != x[31]))
                    : ((x[31] == y[31]) && (r[31] != x[31]));
        e.t = t;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with inputs already set.
    task automatic tick();
        exp_t e;
        #1;
        acc = 1'b0;
        if (out_valid && !out_ready) begin
            if (hold_v) chk("stall_hold", {31'd0, cout, sum}, {31'd0, held});
            held   = {cout, sum};
            hold_v = 1'b1;
        end else begin
            hold_v = 1'b0;
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", {63'd0, out_valid}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("sum", {32'd0, sum}, {32'd0, e.s});
                chk("cout", {63'd0, cout}, {63'd0, e.c});
`ifdef PIPE_ADDER_OVF_EN
                chk("ovf", {63'd0, ovf}, {63'd0, e.o});
`endif
                if (chk_lat) chk("latency", 64'(cyc - e.t), 64'(STG));
                pops++;
            end
        end
        if (in_valid && in_ready && !rst) begin
            sb.push_back(model(a, b, cin, sub, cyc));
            acc = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic ci,
                        input logic s);
        a        = x;
        b        = y;
        cin      = ci;
        sub      = s;
        in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (acc) break;
        end
        chk("send_accept", {63'd0, acc}, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; out_ready16 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sum", {32'd0, sum}, 64'd0);
        chk("rst_cout", {63'd0, cout}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
`ifdef PIPE_ADDER_OVF_EN
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Carry ripples across every segment boundary.
        pops0 = pops;
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        drain(6);
        chk("ripple_pops", 64'(pops - pops0), 64'd1);

        // Subtraction with borrow, then signed overflow on subtract.
        send(32'd5, 32'd7, 1'b1, 1'b1);
        send(32'h8000_0000, 32'd1, 1'b0, 1'b1);
        send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        drain(6);

        // Full-rate back-to-back beats; latency check proves no bubbles.
        pops0 = pops;
        for (int i = 0; i < 8; i++) send(32'h0101_0101 * 32'(i), 32'h00FF_00FF, 1'(i & 1), 1'b0);
        drain(6);
        chk("b2b_pops", 64'(pops - pops0), 64'd8);

        // Backpressure: four beats fill the pipe, the fifth waits.
        chk_lat   = 1'b0;
        pops0     = pops;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'h1000_0000 + 32'(i * 3), 32'(i * 7 + 1), 1'(i & 1), 1'(i >> 1));
        a = 32'hDEAD_BEEF; b = 32'h1234_5678; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        chk("bp_pops_held", 64'(pops - pops0), 64'd0);
        out_ready = 1'b1;
        send(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0);
        send(32'h0000_0003, 32'hFFFF_FFFF, 1'b0, 1'b1);
        drain(8);
        chk("bp_pops", 64'(pops - pops0), 64'd6);
        chk_lat = 1'b1;

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) send(32'hAAAA_0000 + 32'(i), 32'h5555, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_sum", {32'd0, sum}, 64'd0);
        sb.delete();
        tick();
        rst   = 1'b0;
        pops0 = pops;
        send(32'h0000_1234, 32'h0000_4321, 1'b1, 1'b0);
        drain(8);
        chk("post_rst_pops", 64'(pops - pops0), 64'd1);

        // Single-stage instance.
        a16 = 16'h7FFF; b16 = 16'h0001; cin16 = 1'b1; in_valid16 = 1'b1;
        #1;
        chk("s16_in_ready", {63'd0, in_ready16}, 64'd1);
        chk("s16_pre_valid", {63'd0, out_valid16}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid16 = 1'b0;
        #1;
        chk("s16_out_valid", {63'd0, out_valid16}, 64'd1);
        chk("s16_sum", {48'd0, sum16}, 64'h8001);
        chk("s16_cout", {63'd0, cout16}, 64'd0);
`ifdef PIPE_ADDER_OVF_EN
        chk("s16_ovf", {63'd0, ovf16}, 64'd1);
`endif
        @(negedge clk);
        #1;
        chk("s16_bubble", {63'd0, out_valid16}, 64'd0);

        chk("sb_empty_end", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
